// File: rtl/cdc_req_sender_if.sv
// Local source handshake, far-domain strobe/ack pair and status pulses of cdc_req_sender.
// The master modport is the sender block; the slave modport is its surroundings.
interface cdc_req_sender_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  stb_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  ack_in;
   logic                  done;
   logic                  timeout_err;
   logic                  busy;

   modport master (
      input  in_valid, in_data, ack_in,
      output in_ready, stb_out, data_out, done, timeout_err, busy
   );

   modport slave (
      output in_valid, in_data, ack_in,
      input  in_ready, stb_out, data_out, done, timeout_err, busy
   );
endinterface

// File: rtl/cdc_req_sender.sv
// Strobe-side initiator of a 4-phase req/ack crossing: latches one word, raises
// stb_out until the synchronized ack arrives (or a timeout), then waits for ack release.
module cdc_req_sender #(
   parameter int DATA_WIDTH   = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int TIMEOUT      = 1023,
   parameter int TIMEOUT_BITS = 10
) (
   input  logic               clk,
   input  logic               rst,
   cdc_req_sender_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

   localparam logic [TIMEOUT_BITS-1:0] TO_LAST =
      TIMEOUT_BITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   // With the timeout disabled the counter simply saturates at all-ones.
   localparam logic [TIMEOUT_BITS-1:0] CNT_MAX =
      (TIMEOUT == 0) ? {TIMEOUT_BITS{1'b1}} : TO_LAST;

   state_t                  state, state_nxt;
   logic                    stb, stb_nxt;
   logic [DATA_WIDTH-1:0]   data, data_nxt;
   logic                    done_q, done_nxt;
   logic                    terr_q, terr_nxt;
   logic [TIMEOUT_BITS-1:0] cnt, cnt_nxt;
   logic [SYNC_STAGES-1:0]  ack_sync;
   logic                    ack_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ack_sync <= '0;
      else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack_in};
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         stb    <= 1'b0;
         data   <= '0;
         done_q <= 1'b0;
         terr_q <= 1'b0;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         stb    <= stb_nxt;
         data   <= data_nxt;
         done_q <= done_nxt;
         terr_q <= terr_nxt;
         cnt    <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stb_nxt   = stb;
      data_nxt  = data;
      done_nxt  = 1'b0;
      terr_nxt  = 1'b0;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               data_nxt  = bus.in_data;
               stb_nxt   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = REQ;
            end
         end
         REQ: begin
            // Ack is checked first so a same-edge ack beats the timeout.
            if (ack_s) begin
               stb_nxt   = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = REL;
            end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
               stb_nxt   = 1'b0;
               terr_nxt  = 1'b1;
               state_nxt = REL;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         REL: begin
            if (!ack_s) state_nxt = IDLE;
         end
         default: begin
            stb_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.busy        = (state != IDLE);
   assign bus.stb_out     = stb;
   assign bus.data_out    = data;
   assign bus.done        = done_q;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_cdc_req_sender.sv
// Directed bench for cdc_req_sender (SYNC_STAGES=2, TIMEOUT=16); edge numbers in
// comments are relative to the accepting edge of each transfer.
module tb_cdc_req_sender;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   rises  = 0;
   logic stb_q  = 1'b0;
   int   hi;
   logic bad;

   cdc_req_sender_if #(.DATA_WIDTH(32)) dif ();

   cdc_req_sender #(
      .DATA_WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(16), .TIMEOUT_BITS(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(dif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dif.stb_out && !stb_q) rises++;
      stb_q = dif.stb_out;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      dif.in_valid = 1'b0;
      dif.in_data  = '0;
      dif.ack_in   = 1'b0;

      // Power-on reset
      tick(); tick();
      chk("rst_in_ready", dif.in_ready, 1);
      chk("rst_stb", dif.stb_out, 0);
      chk("rst_busy", dif.busy, 0);
      chk("rst_data", dif.data_out, 0);
      chk("rst_done", dif.done, 0);
      chk("rst_terr", dif.timeout_err, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", dif.in_ready, 1);

      // Normal transfer with a second word held by the source (backpressure)
      rises = 0;
      dif.in_valid = 1'b1;
      dif.in_data  = 32'hDEADBEEF;
      tick();                                   // edge 0: accept
      dif.in_data = 32'h12345678;
      chk("acc_stb", dif.stb_out, 1);
      chk("acc_busy", dif.busy, 1);
      chk("acc_in_ready", dif.in_ready, 0);
      chk("acc_data", dif.data_out, 32'hDEADBEEF);
      bad = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         if (!dif.stb_out || dif.done) bad = 1'b1;
      end
      chk("req_hold_1_4", bad, 0);
      dif.ack_in = 1'b1;                        // before edge 5
      tick(); tick();                           // edges 5,6
      chk("stb_edge6", dif.stb_out, 1);
      chk("done_edge6", dif.done, 0);
      tick();                                   // edge 7
      chk("stb_edge7", dif.stb_out, 0);
      chk("done_edge7", dif.done, 1);
      chk("terr_edge7", dif.timeout_err, 0);
      chk("data_rel", dif.data_out, 32'hDEADBEEF);
      tick();                                   // edge 8
      chk("done_edge8", dif.done, 0);
      tick(); tick(); tick();                   // edges 9..11
      chk("rel_in_ready", dif.in_ready, 0);
      dif.ack_in = 1'b0;                        // before edge 12
      tick(); tick();                           // edges 12,13
      chk("in_ready_edge13", dif.in_ready, 0);
      chk("data_edge13", dif.data_out, 32'hDEADBEEF);
      tick();                                   // edge 14
      chk("in_ready_edge14", dif.in_ready, 1);
      chk("data_edge14", dif.data_out, 32'hDEADBEEF);
      chk("stb_edge14", dif.stb_out, 0);

      // Held word accepted at edge 15, then no ack: timeout after 16 strobe cycles
      tick();                                   // edge 15
      dif.in_valid = 1'b0;
      chk("acc2_data", dif.data_out, 32'h12345678);
      chk("acc2_stb", dif.stb_out, 1);
      hi  = 1;
      bad = 1'b0;
      for (int e = 16; e <= 30; e++) begin
         tick();
         if (dif.stb_out) hi++;
         if (dif.done || dif.timeout_err) bad = 1'b1;
      end
      tick();                                   // edge 31
      chk("to_stb_cycles", hi, 16);
      chk("to_no_early_pulse", bad, 0);
      chk("to_stb_fall", dif.stb_out, 0);
      chk("to_terr", dif.timeout_err, 1);
      chk("to_done", dif.done, 0);
      chk("to_in_ready_rel", dif.in_ready, 0);
      tick();                                   // edge 32
      chk("to_terr_clear", dif.timeout_err, 0);
      chk("to_in_ready", dif.in_ready, 1);
      chk("stb_pulses", rises, 2);
      chk("data_after_to", dif.data_out, 32'h12345678);

      // Ack/timeout race: ack_s rises at the edge where counter==15
      dif.in_valid = 1'b1;
      dif.in_data  = 32'hA5A5A5A5;
      tick();                                   // edge 0
      dif.in_valid = 1'b0;
      for (int e = 1; e <= 13; e++) tick();
      dif.ack_in = 1'b1;                        // before edge 14
      tick(); tick();                           // edges 14,15
      chk("race_stb15", dif.stb_out, 1);
      tick();                                   // edge 16
      chk("race_done", dif.done, 1);
      chk("race_terr", dif.timeout_err, 0);
      chk("race_stb", dif.stb_out, 0);

      // Stuck ack keeps the FSM in REL
      for (int e = 0; e < 5; e++) tick();
      chk("stuck_in_ready", dif.in_ready, 0);
      chk("stuck_stb", dif.stb_out, 0);
      chk("stuck_busy", dif.busy, 1);
      chk("stuck_done", dif.done, 0);
      dif.ack_in = 1'b0;                        // before edge E
      tick(); tick();                           // E, E+1
      chk("release_e1", dif.in_ready, 0);
      tick();                                   // E+2
      chk("release_e2", dif.in_ready, 1);

      // Ack while IDLE is ignored
      dif.ack_in = 1'b1;
      for (int e = 0; e < 4; e++) tick();
      chk("idle_ack_stb", dif.stb_out, 0);
      chk("idle_ack_done", dif.done, 0);
      chk("idle_ack_in_ready", dif.in_ready, 1);
      chk("idle_ack_data", dif.data_out, 32'hA5A5A5A5);
      dif.ack_in = 1'b0;
      tick(); tick(); tick();

      // Reset in the middle of a request
      dif.in_valid = 1'b1;
      dif.in_data  = 32'h0BADF00D;
      tick();
      dif.in_valid = 1'b0;
      chk("mid_stb_before", dif.stb_out, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_stb", dif.stb_out, 0);
      chk("mid_rst_busy", dif.busy, 0);
      chk("mid_rst_done", dif.done, 0);
      chk("mid_rst_terr", dif.timeout_err, 0);
      chk("mid_rst_data", dif.data_out, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_in_ready", dif.in_ready, 1);
      chk("mid_rst_no_pulse", dif.done | dif.timeout_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
